// File: rtl/match_pkg.sv
// match_pkg: shared state encoding, who encodings and tally width for the match controller.
package match_pkg;
    typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;
    localparam logic [1:0] WHO_NONE = 2'b00;
    localparam logic [1:0] WHO_P1   = 2'b01;
    localparam logic [1:0] WHO_P2   = 2'b10;
    localparam logic [1:0] WHO_BAD  = 2'b11;
    localparam int TALLY_W = 4;
endpackage

// File: rtl/pause_timer.sv
// pause_timer: down-counter loaded with CYCLES; expired flags the last cycle of the pause.
module pause_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? 8'(CYCLES) : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    // Expiring at 1 lets the owner leave on the edge that ends cycle CYCLES.
    assign expired = cnt_q == 8'd1;
endmodule

// File: rtl/match_ctrl.sv
// match_ctrl: best-of match sequencer tallying game results with pauses between games.
module match_ctrl
    import match_pkg::*;
#(
    parameter int GAMES_TO_WIN = 3,
    parameter int PAUSE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gameover,
    input  logic [1:0]       who,
    input  logic             ack,
    output logic             run,
    output logic [TALLY_W-1:0] wins_p1,
    output logic [TALLY_W-1:0] wins_p2,
    output logic [4:0]       games,
    output logic             match_over,
    output logic [1:0]       match_winner,
    output logic             err
);
    localparam logic [TALLY_W-1:0] TARGET = TALLY_W'(GAMES_TO_WIN);

    state_t state_q, state_d;
    logic [TALLY_W-1:0] wins_p1_q, wins_p1_d, wins_p2_q, wins_p2_d;
    logic [4:0] games_q, games_d;
    logic [1:0] winner_q, winner_d;
    logic run_q, run_d, over_q, over_d, err_q, err_d;
    logic load, expired, legal;

    assign legal = who == WHO_P1 || who == WHO_P2;

    always_comb begin
        state_d = state_q;
        wins_p1_d = wins_p1_q;
        wins_p2_d = wins_p2_q;
        games_d = games_q;
        winner_d = winner_q;
        over_d = over_q;
        err_d = err_q;
        load = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = PLAY;
                wins_p1_d = '0;
                wins_p2_d = '0;
                games_d = '0;
                err_d = 1'b0;
            end
            PLAY: if (gameover && !legal) err_d = 1'b1;
            else if (gameover) begin
                wins_p1_d = wins_p1_q + TALLY_W'(who == WHO_P1);
                wins_p2_d = wins_p2_q + TALLY_W'(who == WHO_P2);
                games_d = games_q == 5'd31 ? games_q : games_q + 5'd1;
                if (wins_p1_d == TARGET || wins_p2_d == TARGET) begin
                    state_d = DONE;
                    over_d = 1'b1;
                    winner_d = who;
                end else begin
                    state_d = PAUSE;
                    load = 1'b1;
                end
            end
            PAUSE: if (expired) state_d = PLAY;
            DONE: if (ack) begin
                state_d = IDLE;
                over_d = 1'b0;
                winner_d = WHO_NONE;
            end
            default: ;
        endcase
        // Decoding the next state keeps run a plain flop aligned with the state register.
        run_d = state_d == PLAY;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wins_p1_q <= '0;
            wins_p2_q <= '0;
            games_q <= '0;
            winner_q <= WHO_NONE;
            run_q <= 1'b0;
            over_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wins_p1_q <= wins_p1_d;
            wins_p2_q <= wins_p2_d;
            games_q <= games_d;
            winner_q <= winner_d;
            run_q <= run_d;
            over_q <= over_d;
            err_q <= err_d;
        end
    end

    pause_timer #(.CYCLES(PAUSE_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(load),
        .expired(expired)
    );

    assign run = run_q;
    assign wins_p1 = wins_p1_q;
    assign wins_p2 = wins_p2_q;
    assign games = games_q;
    assign match_over = over_q;
    assign match_winner = winner_q;
    assign err = err_q;
endmodule
